// File: rtl/axis_xbar_rr_if.sv
// axis_xbar_rr_if: ingress and egress AXI-Stream bundles of the round-robin packet crossbar
interface axis_xbar_rr_if #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = 2
);
  localparam int KEEP_W = DATA_W / 8;
  logic [N_IN-1:0]         s_axis_tvalid;
  logic [N_IN-1:0]         s_axis_tready;
  logic [N_IN*DATA_W-1:0]  s_axis_tdata;
  logic [N_IN*KEEP_W-1:0]  s_axis_tkeep;
  logic [N_IN-1:0]         s_axis_tlast;
  logic [N_IN*DEST_W-1:0]  s_axis_tdest;
  logic [N_OUT-1:0]        m_axis_tvalid;
  logic [N_OUT-1:0]        m_axis_tready;
  logic [N_OUT*DATA_W-1:0] m_axis_tdata;
  logic [N_OUT*KEEP_W-1:0] m_axis_tkeep;
  logic [N_OUT-1:0]        m_axis_tlast;
  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/axis_xbar_rr.sv
// axis_xbar_rr: N_IN x N_OUT AXI-Stream packet crossbar, TDEST routed, per-egress round-robin,
// grants locked for a whole packet, unroutable packets swallowed and counted.
module axis_xbar_rr #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = 2
) (
  input  logic                  glb_clk,
  input  logic                  glb_areset_n,
  axis_xbar_rr_if.master        bus,
  output logic [N_OUT*N_IN-1:0] grant_vec,
  output logic [15:0]           drop_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int IW     = $clog2(N_IN);
  typedef enum logic [1:0] {FREE, ROUTED, DROP} in_st_t;
  typedef enum logic {IDLE, BUSY} out_st_t;
  in_st_t                  r_in_st [N_IN];
  in_st_t                  w_in_nx [N_IN];
  out_st_t                 r_out_st [N_OUT];
  out_st_t                 w_out_nx [N_OUT];
  logic [IW-1:0]           r_own [N_OUT];
  logic [IW-1:0]           w_own_nx [N_OUT];
  logic [IW-1:0]           r_ptr [N_OUT];
  logic [IW-1:0]           w_ptr_nx [N_OUT];
  logic [DEST_W-1:0]       w_dest [N_IN];
  logic [N_IN-1:0]         w_granted;
  logic [N_IN-1:0]         w_s_tready;
  logic [N_IN-1:0]         w_drop_new;
  logic [N_OUT-1:0]        w_busy;
  logic [N_OUT-1:0]        w_m_tvalid;
  logic [N_OUT-1:0]        w_m_tlast;
  logic [N_OUT-1:0]        w_done;
  logic [N_OUT*DATA_W-1:0] w_m_tdata;
  logic [N_OUT*KEEP_W-1:0] w_m_tkeep;
  logic [15:0]             r_drop_cnt;
  logic [15:0]             w_drop_nx;

  always_comb begin
    for (int i = 0; i < N_IN; i++) w_dest[i] = bus.s_axis_tdest[i*DEST_W +: DEST_W];
  end

  // Busy egress is a pure combinational mux from its owner, so no latency is added.
  always_comb begin
    w_busy     = '0;
    w_m_tvalid = '0;
    w_m_tlast  = '0;
    w_done     = '0;
    w_m_tdata  = '0;
    w_m_tkeep  = '0;
    grant_vec  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_busy[j]     = r_out_st[j] == BUSY;
      w_m_tvalid[j] = w_busy[j] && bus.s_axis_tvalid[r_own[j]];
      w_m_tlast[j]  = bus.s_axis_tlast[r_own[j]];
      w_m_tdata[j*DATA_W +: DATA_W] = bus.s_axis_tdata[r_own[j]*DATA_W +: DATA_W];
      w_m_tkeep[j*KEEP_W +: KEEP_W] = bus.s_axis_tkeep[r_own[j]*KEEP_W +: KEEP_W];
      w_done[j]     = w_m_tvalid[j] && bus.m_axis_tready[j] && w_m_tlast[j];
      grant_vec[j*N_IN +: N_IN] = w_busy[j] ? N_IN'(1) << r_own[j] : '0;
    end
  end

  always_comb begin
    w_s_tready = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_s_tready[i] = r_in_st[i] == DROP;
      for (int j = 0; j < N_OUT; j++)
        w_s_tready[i] = w_s_tready[i] | (w_busy[j] && int'(r_own[j]) == i && bus.m_axis_tready[j]);
    end
  end

  // Scanning downwards lets the nearest requester at or after the pointer win last.
  always_comb begin : p_arb
    logic [IW-1:0] idx;
    idx       = '0;
    w_granted = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_out_nx[j] = r_out_st[j];
      w_own_nx[j] = r_own[j];
      w_ptr_nx[j] = r_ptr[j];
      if (!w_busy[j]) begin
        for (int k = N_IN - 1; k >= 0; k--) begin
          idx = IW'((int'(r_ptr[j]) + k) % N_IN);
          if (r_in_st[idx] == FREE && bus.s_axis_tvalid[idx] && int'(w_dest[idx]) == j) begin
            w_out_nx[j] = BUSY;
            w_own_nx[j] = idx;
          end
        end
        if (w_out_nx[j] == BUSY) w_granted[w_own_nx[j]] = 1'b1;
      end else if (w_done[j]) begin
        w_out_nx[j] = IDLE;
        w_ptr_nx[j] = int'(r_own[j]) == N_IN - 1 ? '0 : r_own[j] + 1'b1;
      end
    end
  end

  always_comb begin
    w_drop_new = '0;
    w_drop_nx  = r_drop_cnt;
    for (int i = 0; i < N_IN; i++) begin
      w_in_nx[i] = r_in_st[i];
      if (r_in_st[i] == FREE && bus.s_axis_tvalid[i]) begin
        w_drop_new[i] = int'(w_dest[i]) >= N_OUT;
        w_in_nx[i]    = w_drop_new[i] ? DROP : w_granted[i] ? ROUTED : FREE;
      end else if (r_in_st[i] != FREE && bus.s_axis_tvalid[i] && w_s_tready[i] && bus.s_axis_tlast[i])
        w_in_nx[i] = FREE;
      if (w_drop_new[i] && w_drop_nx != 16'hFFFF) w_drop_nx = w_drop_nx + 1'b1;
    end
  end

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      for (int i = 0; i < N_IN; i++) r_in_st[i] <= FREE;
      for (int j = 0; j < N_OUT; j++) begin
        r_out_st[j] <= IDLE;
        r_own[j]    <= '0;
        r_ptr[j]    <= '0;
      end
      r_drop_cnt <= '0;
    end else begin
      r_in_st    <= w_in_nx;
      r_out_st   <= w_out_nx;
      r_own      <= w_own_nx;
      r_ptr      <= w_ptr_nx;
      r_drop_cnt <= w_drop_nx;
    end
  end

  assign bus.s_axis_tready = w_s_tready;
  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.m_axis_tdata  = w_m_tdata;
  assign bus.m_axis_tkeep  = w_m_tkeep;
  assign bus.m_axis_tlast  = w_m_tlast;
  assign drop_cnt          = r_drop_cnt;
endmodule

// File: tb/tb_axis_xbar_rr.sv
// tb_axis_xbar_rr: directed checks of routing, round-robin order, packet lock, parallel flow,
// drops, backpressure and asynchronous reset of axis_xbar_rr.
module tb_axis_xbar_rr;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 32;
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; logic [1:0] dest; int gap; } beat_t;
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; int cyc; } rx_t;
  logic        glb_clk = 1'b0;
  logic        glb_areset_n = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          waited [NI];
  beat_t       q_in [NI][$];
  rx_t         rx [NO][$];
  logic [NI-1:0] fire;
  logic [NO-1:0] mr_base = '1;
  logic [NO-1:0] tog_mask = '0;
  logic [15:0] grant_vec;
  logic [15:0] drop_cnt;
  logic [11:0] grant3;
  logic [15:0] drop3;

  axis_xbar_rr_if #(.N_IN(4), .N_OUT(4), .DATA_W(32), .DEST_W(2)) bus ();
  axis_xbar_rr_if #(.N_IN(4), .N_OUT(3), .DATA_W(32), .DEST_W(2)) bus3 ();

  axis_xbar_rr #(.N_IN(4), .N_OUT(4), .DATA_W(32), .DEST_W(2)) u_dut (
    .glb_clk(glb_clk), .glb_areset_n(glb_areset_n), .bus(bus), .grant_vec(grant_vec), .drop_cnt(drop_cnt)
  );
  axis_xbar_rr #(.N_IN(4), .N_OUT(3), .DATA_W(32), .DEST_W(2)) u_drp (
    .glb_clk(glb_clk), .glb_areset_n(glb_areset_n), .bus(bus3), .grant_vec(grant3), .drop_cnt(drop3)
  );

  always #5 glb_clk = ~glb_clk;
  always @(posedge glb_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int i, input int dest, input int id, input int k);
    return {4'(i), 4'(dest), 8'(id), 16'(k)};
  endfunction

  task automatic push_pkt(input int i, input int dest, input int n, input int id, input int gap);
    for (int k = 0; k < n; k++)
      q_in[i].push_back('{mk(i, dest, id, k), (k == n-1) ? 4'h3 : 4'hF, k == n-1, 2'(dest), k == 0 ? 0 : gap});
  endtask

  task automatic chk_pkt(input string tag, input int j, input int i, input int dest, input int n,
                         input int id, input int c0);
    rx_t r;
    chk({tag, "_cnt"}, 64'(rx[j].size() >= n), 1);
    if (rx[j].size() < n) return;
    for (int k = 0; k < n; k++) begin
      r = rx[j].pop_front();
      chk({tag, "_data"}, r.data, mk(i, dest, id, k));
      chk({tag, "_keep"}, r.keep, (k == n-1) ? 4'h3 : 4'hF);
      chk({tag, "_last"}, r.last, k == n-1);
      if (c0 >= 0) chk({tag, "_cyc"}, r.cyc, c0 + k);
    end
  endtask

  function automatic bit tb_busy();
    bit b = (bus.m_axis_tvalid != 0) || (grant_vec != 0);
    for (int i = 0; i < NI; i++) b |= q_in[i].size() > 0;
    return b;
  endfunction

  task automatic wait_idle(input string tag);
    int t = 0;
    while (tb_busy() && t < 300) begin
      @(negedge glb_clk);
      t++;
    end
    chk({tag, "_idle"}, 64'(t < 300), 1);
  endtask

  task automatic clear_rx();
    for (int j = 0; j < NO; j++) rx[j].delete();
  endtask

  // Source/sink model: sample handshakes mid-cycle, advance sources just after the edge.
  initial begin : drv
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tdest  = '0;
    bus.m_axis_tready = mr_base;
    for (int i = 0; i < NI; i++) waited[i] = 0;
    forever begin
      @(negedge glb_clk);
      fire = bus.s_axis_tvalid & bus.s_axis_tready;
      for (int j = 0; j < NO; j++)
        if (bus.m_axis_tvalid[j] && bus.m_axis_tready[j])
          rx[j].push_back('{bus.m_axis_tdata[j*DW +: DW], bus.m_axis_tkeep[j*4 +: 4], bus.m_axis_tlast[j], cyc});
      @(posedge glb_clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (fire[i] && q_in[i].size() > 0) begin
          void'(q_in[i].pop_front());
          waited[i] = 0;
        end
        if (q_in[i].size() == 0) bus.s_axis_tvalid[i] = 1'b0;
        else if (waited[i] < q_in[i][0].gap) begin
          bus.s_axis_tvalid[i] = 1'b0;
          waited[i]++;
        end else begin
          bus.s_axis_tvalid[i]          = 1'b1;
          bus.s_axis_tdata[i*DW +: DW]  = q_in[i][0].data;
          bus.s_axis_tkeep[i*4 +: 4]    = q_in[i][0].keep;
          bus.s_axis_tlast[i]           = q_in[i][0].last;
          bus.s_axis_tdest[i*2 +: 2]    = q_in[i][0].dest;
        end
      end
      bus.m_axis_tready = mr_base & ~(tog_mask & {NO{cyc[0]}});
    end
  end

  initial begin : main
    bus3.s_axis_tvalid = '0;
    bus3.s_axis_tdata  = '0;
    bus3.s_axis_tkeep  = '1;
    bus3.s_axis_tlast  = '0;
    bus3.s_axis_tdest  = '0;
    bus3.m_axis_tready = 3'b111;
    #2 glb_areset_n = 1'b0;
    repeat (2) @(negedge glb_clk);
    chk("rst_mvalid", bus.m_axis_tvalid, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_grant", grant_vec, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_grant3", grant3, 0);
    glb_areset_n = 1'b1;
    @(negedge glb_clk);

    // route: in0 -> m2, one arbitration cycle then four back-to-back beats
    t0 = cyc;
    push_pkt(0, 2, 4, 1, 0);
    @(negedge glb_clk);
    chk("t1_grant_c0", grant_vec, 16'h0000);
    chk("t1_tready_c0", bus.s_axis_tready, 4'h0);
    @(negedge glb_clk);
    chk("t1_grant", grant_vec, 16'h0100);
    chk("t1_mvalid", bus.m_axis_tvalid, 4'b0100);
    repeat (4) @(negedge glb_clk);
    chk("t1_rel_grant", grant_vec, 16'h0000);
    chk("t1_rel_mvalid", bus.m_axis_tvalid, 4'b0000);
    chk_pkt("t1", 2, 0, 2, 4, 1, t0 + 2);

    // round-robin on m1: in0,in1,in2,in3,in0 with one idle cycle between packets
    clear_rx();
    t0 = cyc;
    for (int i = 0; i < 4; i++) push_pkt(i, 1, 2, 2, 0);
    push_pkt(0, 1, 2, 3, 0);
    wait_idle("t2");
    chk_pkt("t2_in0", 1, 0, 1, 2, 2, t0 + 2);
    chk_pkt("t2_in1", 1, 1, 1, 2, 2, t0 + 5);
    chk_pkt("t2_in2", 1, 2, 1, 2, 2, t0 + 8);
    chk_pkt("t2_in3", 1, 3, 1, 2, 2, t0 + 11);
    chk_pkt("t2_in0b", 1, 0, 1, 2, 3, t0 + 14);

    // lock: in1 owns m0 through 3-cycle bubbles while in2 waits
    clear_rx();
    t0 = cyc;
    push_pkt(1, 0, 3, 4, 3);
    push_pkt(2, 0, 2, 4, 0);
    repeat (4) @(negedge glb_clk);
    chk("t3_lock", grant_vec[3:0], 4'b0010);
    chk("t3_wait", bus.s_axis_tready[2], 1'b0);
    chk("t3_bubble", bus.m_axis_tvalid[0], 1'b0);
    wait_idle("t3");
    chk("t3_total", rx[0].size(), 5);
    if (rx[0].size() == 5) begin
      chk("t3_b0_cyc", rx[0][0].cyc, t0 + 2);
      chk("t3_b1_cyc", rx[0][1].cyc, t0 + 6);
      chk("t3_b2_cyc", rx[0][2].cyc, t0 + 10);
    end
    chk_pkt("t3_in1", 0, 1, 0, 3, 4, -1);
    chk_pkt("t3_in2", 0, 2, 0, 2, 4, t0 + 12);

    // parallel: in0 -> m3 and in3 -> m0 concurrently
    clear_rx();
    t0 = cyc;
    push_pkt(0, 3, 8, 5, 0);
    push_pkt(3, 0, 8, 5, 0);
    wait_idle("t4");
    chk_pkt("t4_m3", 3, 0, 3, 8, 5, t0 + 2);
    chk_pkt("t4_m0", 0, 3, 0, 8, 5, t0 + 2);

    // backpressure: m2 tready toggling every cycle
    clear_rx();
    tog_mask = 4'b0100;
    push_pkt(1, 2, 6, 6, 0);
    wait_idle("t5");
    tog_mask = '0;
    chk("t5_total", rx[2].size(), 6);
    chk_pkt("t5", 2, 1, 2, 6, 6, -1);

    // drop on the 3-output instance: tdest 3 is unroutable
    @(negedge glb_clk);
    bus3.s_axis_tdest = 8'b00_11_00_00;
    bus3.s_axis_tdata[64 +: 32] = 32'hD000_0000;
    bus3.s_axis_tvalid = 4'b0100;
    #1;
    chk("t6_free_tready", bus3.s_axis_tready[2], 1'b0);
    chk("t6_cnt0", drop3, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge glb_clk);
      bus3.s_axis_tdata[64 +: 32] = 32'hD000_0000 + 32'(k);
      bus3.s_axis_tlast[2] = k == 4;
      #1;
      chk($sformatf("t6_tready%0d", k), bus3.s_axis_tready[2], 1'b1);
      chk($sformatf("t6_mvalid%0d", k), bus3.m_axis_tvalid, 3'b000);
      if (k == 0) chk("t6_cnt1", drop3, 1);
    end
    @(negedge glb_clk);
    bus3.s_axis_tvalid = '0;
    bus3.s_axis_tlast  = '0;
    #1;
    chk("t6_back_free", bus3.s_axis_tready[2], 1'b0);
    chk("t6_cnt_final", drop3, 1);
    chk("t6_grant3", grant3, 0);

    // reset mid-packet aborts everything at once
    clear_rx();
    @(negedge glb_clk);
    push_pkt(0, 1, 6, 7, 0);
    repeat (3) @(negedge glb_clk);
    chk("t7_pre_mvalid", bus.m_axis_tvalid, 4'b0010);
    #1 glb_areset_n = 1'b0;
    #1;
    chk("t7_mvalid", bus.m_axis_tvalid, 0);
    chk("t7_grant", grant_vec, 0);
    chk("t7_tready", bus.s_axis_tready, 0);
    chk("t7_drop", drop_cnt, 0);
    chk("t7_drop3", drop3, 0);
    for (int i = 0; i < NI; i++) begin
      q_in[i].delete();
      waited[i] = 0;
    end
    repeat (2) @(negedge glb_clk);
    glb_areset_n = 1'b1;
    @(negedge glb_clk);
    clear_rx();

    // recovery with a single-beat packet in2 -> m3
    t0 = cyc;
    push_pkt(2, 3, 1, 8, 0);
    wait_idle("t8");
    chk_pkt("t8", 3, 2, 3, 1, 8, t0 + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
